// File: rtl/seg7_scan_if.sv
// ============================================================================
// Module  : seg7_scan_if
// Brief   : CPU-side control/write bus of the 7-segment scan controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg7_scan_if;
    logic       enable;
    logic [2:0] bright;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;

    modport master (output enable, bright, wr_en, wr_addr, wr_data);
    modport slave  (input  enable, bright, wr_en, wr_addr, wr_data);
endinterface

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module  : seg7_scan_ctrl
// Brief   : 4-digit 7-segment scan controller with blanking, brightness and
//           frame-boundary updates. Option: SEG7_SCAN_HEX_DECODE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 64
) (
    input  wire logic       clk,
    input  wire logic       resetb,
    seg7_scan_if.slave      bus,
    output logic [7:0]      abcdefgh_n_o,
    output logic [3:0]      digit_n_o,
    output logic            frame_tick_o,
    output logic [1:0]      scan_idx_o
);

    localparam int DIGIT_CYCLES = CLK_HZ / SCAN_HZ;
    localparam int SPAN         = DIGIT_CYCLES - BLANK_CYCLES;
    localparam int CW           = $clog2(DIGIT_CYCLES);

    localparam logic [CW-1:0] C_LAST       = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] C_PRE        = CW'(DIGIT_CYCLES - 2);
    localparam logic [CW-1:0] C_BLANK_LAST = CW'(BLANK_CYCLES - 1);

    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_ON    = 2'd2;
    localparam logic [1:0] S_DARK  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] on_end_q, on_end_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    dig_q, dig_d;
    logic          ft_q, ft_d;
    logic [7:0]    shadow_q [0:3];
    logic [7:0]    active_q [0:3];
    logic [7:0]    w_shadow_fwd [0:3];
    logic          w_slot_end;
    logic          w_load;
    logic [31:0]   w_on_len;
    logic [CW-1:0] w_on_end;
    logic [7:0]    w_seg_on;

`ifdef SEG7_SCAN_HEX_DECODE_EN
    function automatic logic [6:0] f_hex(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
            4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
            4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  default: s = 7'h47;
        endcase
        return s;
    endfunction

    assign w_seg_on = {f_hex(active_q[idx_q][3:0]), active_q[idx_q][4]};
`else
    assign w_seg_on = active_q[idx_q];
`endif

    // Lit window of the slot, measured from the end of blanking.
    assign w_on_len = (32'(SPAN) * ({29'd0, bus.bright} + 32'd1)) >> 3;
    assign w_on_end = CW'(32'(BLANK_CYCLES) + w_on_len - 32'd1);

    // A write landing in the copy cycle is forwarded so it is not lost.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_shadow_fwd[i] = (bus.wr_en && (bus.wr_addr == 2'(i))) ? bus.wr_data : shadow_q[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        on_end_d   = on_end_q;
        w_slot_end = 1'b0;
        w_load     = 1'b0;
        if (!bus.enable) begin
            state_d = S_OFF;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    w_load  = 1'b1;
                end
                S_BLANK: begin
                    if (cnt_q == C_BLANK_LAST) begin
                        state_d  = S_ON;
                        on_end_d = w_on_end;
                    end
                end
                S_ON: begin
                    if (cnt_q == C_LAST)
                        w_slot_end = 1'b1;
                    else if (cnt_q == on_end_q)
                        state_d = S_DARK;
                end
                S_DARK: begin
                    if (cnt_q == C_LAST)
                        w_slot_end = 1'b1;
                end
                default: state_d = S_OFF;
            endcase
            if (w_slot_end) begin
                state_d = S_BLANK;
                cnt_d   = '0;
                idx_d   = idx_q + 2'd1;
                w_load  = (idx_q == 2'd3);
            end
        end
    end

    // Tick is raised for the cycle in which the frame-end copy happens.
    assign ft_d = bus.enable && ((state_q == S_ON) || (state_q == S_DARK)) &&
                  (cnt_q == C_PRE) && (idx_q == 2'd3);

    always_comb begin
        seg_d = 8'hFF;
        dig_d = 4'hF;
        if (bus.enable && (state_q == S_ON)) begin
            seg_d = ~w_seg_on;
            dig_d = ~(4'b0001 << idx_q);
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q  <= S_OFF;
            cnt_q    <= '0;
            idx_q    <= '0;
            on_end_q <= '0;
            seg_q    <= 8'hFF;
            dig_q    <= 4'hF;
            ft_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            on_end_q <= on_end_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
            ft_q     <= ft_d;
            if (bus.wr_en)
                shadow_q[bus.wr_addr] <= bus.wr_data;
            if (w_load) begin
                for (int i = 0; i < 4; i++)
                    active_q[i] <= w_shadow_fwd[i];
            end
        end
    end

    assign abcdefgh_n_o = seg_q;
    assign digit_n_o    = dig_q;
    assign frame_tick_o = ft_q;
    assign scan_idx_o   = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// Module  : tb_seg7_scan_ctrl
// Brief   : Directed self-checking bench for seg7_scan_ctrl (16-cycle slots).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic [7:0] abcdefgh_n;
    logic [3:0] digit_n;
    logic       frame_tick;
    logic [1:0] scan_idx;

    int checks = 0;
    int errors = 0;
    int k      = 0;   // clock edges since the enable edge of the current run
    int epoch  = 0;
    bit running = 1'b0;

    seg7_scan_if bus ();

    seg7_scan_ctrl #(
        .CLK_HZ      (1600),
        .SCAN_HZ     (100),
        .BLANK_CYCLES(2)
    ) dut (
        .clk         (clk),
        .resetb      (resetb),
        .bus         (bus),
        .abcdefgh_n_o(abcdefgh_n),
        .digit_n_o   (digit_n),
        .frame_tick_o(frame_tick),
        .scan_idx_o  (scan_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [7:0] enc(input logic [7:0] v);
`ifdef SEG7_SCAN_HEX_DECODE_EN
        logic [6:0] t [0:15];
        t = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        return {t[v[3:0]], v[4]};
`else
        return v;
`endif
    endfunction

    // Lit cycles per slot: bright 7 -> 14, bright 0 -> 1 (slots 8..12 of run 0).
    function automatic int son(input int s);
        if (epoch == 0 && s >= 8 && s <= 12) return 1;
        return 14;
    endfunction

    function automatic logic [7:0] dat(input int d, input int f);
        logic [7:0] base [0:3];
        base = '{8'h81, 8'h42, 8'h24, 8'h18};
        if (epoch == 2) return 8'h00;
        if (d == 1 && (epoch == 1 || f >= 5)) return 8'h3C;
        if (d == 2 && (epoch == 1 || f >= 6)) return 8'h99;
        if (d == 3 && epoch == 1) return 8'h5A;
        return base[d];
    endfunction

    task automatic check_now();
        logic [3:0] e_dig = 4'hF;
        logic [7:0] e_seg = 8'hFF;
        logic       e_ft  = 1'b0;
        logic [1:0] e_idx = 2'd0;
        if (running) begin
            e_idx = 2'(((k - 1) / 16) % 4);
            if (k >= 2) begin
                int t = k - 2;
                int s = t / 16;
                int c = t % 16;
                int d = s % 4;
                e_ft = (t % 64 == 62);
                if (c >= 2 && c < 2 + son(s)) begin
                    e_dig = ~(4'b0001 << d);
                    e_seg = ~enc(dat(d, s / 4));
                end
            end
        end
        chk("digit_n", {4'h0, digit_n}, {4'h0, e_dig});
        chk("abcdefgh_n", abcdefgh_n, e_seg);
        chk("frame_tick", {7'h0, frame_tick}, {7'h0, e_ft});
        chk("scan_idx", {6'h0, scan_idx}, {6'h0, e_idx});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
        check_now();
    endtask

    task automatic run_to(input int kk);
        while (k < kk) step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    initial begin
        bus.enable = 1'b0; bus.bright = 3'd7;
        bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 8'h00;
        #12;
        chk("reset digit_n", {4'h0, digit_n}, 8'h0F);
        chk("reset abcdefgh_n", abcdefgh_n, 8'hFF);
        chk("reset frame_tick", {7'h0, frame_tick}, 8'h00);
        chk("reset scan_idx", {6'h0, scan_idx}, 8'h00);
        resetb = 1'b1;
        step();

        // Load digits while disabled; display must stay dark.
        wr(2'd0, 8'h81); wr(2'd1, 8'h42); wr(2'd2, 8'h24); wr(2'd3, 8'h18);
        step();

        // Full brightness, two frames.
        bus.enable = 1'b1; running = 1'b1; k = 0;
        run_to(129);
        // Dim to minimum from slot 8; raise again mid-slot 12 (takes effect slot 13).
        bus.bright = 3'd0;
        run_to(200);
        bus.bright = 3'd7;
        // Write during digit-1 slot of frame 4: shown from frame 5.
        run_to(280);
        wr(2'd1, 8'h3C);
        // Write coincident with the frame-5 tick: shown from frame 6.
        run_to(384);
        wr(2'd2, 8'h99);
        // Drop enable inside the lit part of digit 2 (slot 26).
        run_to(422);
        bus.enable = 1'b0; running = 1'b0;
        step();
        wr(2'd3, 8'h5A);
        step(); step();

        // Re-enable: shadow reloaded at once, scanning restarts at digit 0.
        epoch = 1; bus.enable = 1'b1; running = 1'b1; k = 0;
        run_to(90);

        // Asynchronous reset mid-frame.
        #2 resetb = 1'b0;
        #1;
        chk("async rst digit_n", {4'h0, digit_n}, 8'h0F);
        chk("async rst abcdefgh_n", abcdefgh_n, 8'hFF);
        chk("async rst frame_tick", {7'h0, frame_tick}, 8'h00);
        chk("async rst scan_idx", {6'h0, scan_idx}, 8'h00);
        #1 resetb = 1'b1;
        epoch = 2; k = 0;
        run_to(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
